// File: rtl/row_frame_server.sv
// Row-request responder: packs a raster pixel stream into row words, buffers
// one frame of rows, and serves the row selected by the requested index.
module row_frame_server #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 15,
  parameter int NUM_ROWS = 15,
  parameter int REQ_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid_i,
  input  logic [PIX_W-1:0]         pix_data_i,
  output logic                     pix_ready_o,
  input  logic                     frame_clear_i,
  input  logic [REQ_W-1:0]         req_row_i,
  output logic [PIX_W*ROW_PIX-1:0] in_row_o,
  output logic                     row_valid_o,
  output logic [4:0]               rows_loaded_o,
  output logic                     frame_done_o
);

  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int COL_W = $clog2(ROW_PIX);
  localparam int IDX_W = $clog2(NUM_ROWS);

  typedef enum logic {LOAD, FULL} state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [4:0]          rows_loaded_q, rows_loaded_d;
  logic [PIX_W-1:0]    pack_q [ROW_PIX-1];
  logic [ROW_W-1:0]    mem_q  [NUM_ROWS];
  logic [ROW_W-1:0]    in_row_q;
  logic                row_valid_q;

  logic                beat;
  logic                last_col;
  logic                commit;
  logic                req_hit;
  logic [ROW_W-1:0]    row_word;

  // Clear takes priority over a coincident beat, so the pixel is dropped.
  assign beat     = pix_valid_i && (state_q == LOAD) && !frame_clear_i;
  assign last_col = (col_cnt_q == COL_W'(ROW_PIX - 1));
  assign commit   = beat && last_col;
  assign req_hit  = (req_row_i < REQ_W'(rows_loaded_q));

  // The last pixel of a row bypasses the pack register straight into memory.
  always_comb begin
    row_word = '0;
    for (int c = 0; c < ROW_PIX - 1; c++) begin
      row_word[c*PIX_W +: PIX_W] = pack_q[c];
    end
    row_word[ROW_W-1 -: PIX_W] = pix_data_i;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    col_cnt_d     = col_cnt_q;
    rows_loaded_d = rows_loaded_q;
    if (frame_clear_i) begin
      state_d       = LOAD;
      col_cnt_d     = '0;
      rows_loaded_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat) begin
            if (last_col) begin
              col_cnt_d     = '0;
              rows_loaded_d = rows_loaded_q + 5'd1;
              if (rows_loaded_q == 5'(NUM_ROWS - 1)) state_d = FULL;
            end else begin
              col_cnt_d = col_cnt_q + COL_W'(1);
            end
          end
        end
        FULL: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      col_cnt_q     <= '0;
      rows_loaded_q <= '0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      rows_loaded_q <= rows_loaded_d;
    end
  end

  // NOTE: pack and row storage are not reset; rows_loaded gates every read instead.
  always_ff @(posedge clk) begin
    if (beat && !last_col) pack_q[col_cnt_q] <= pix_data_i;
    if (commit) mem_q[rows_loaded_q[IDX_W-1:0]] <= row_word;
  end

  // Read compares against rows_loaded before any same-cycle commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_row_q    <= '0;
      row_valid_q <= 1'b0;
    end else begin
      in_row_q    <= req_hit ? mem_q[req_row_i[IDX_W-1:0]] : '0;
      row_valid_q <= req_hit;
    end
  end

  assign pix_ready_o   = (state_q == LOAD) && !rst;
  assign frame_done_o  = (state_q == FULL);
  assign rows_loaded_o = rows_loaded_q;
  assign in_row_o      = in_row_q;
  assign row_valid_o   = row_valid_q;

endmodule

// File: tb/tb_row_frame_server.sv
// Directed bench for row_frame_server: frame load, read latency, range checks,
// gapped input, clear priority and asynchronous reset.
module tb_row_frame_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_ready;
  logic         frame_clear;
  logic [63:0]  req_row;
  logic [119:0] in_row;
  logic         row_valid;
  logic [4:0]   rows_loaded;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  row_frame_server dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid_i   (pix_valid),
    .pix_data_i    (pix_data),
    .pix_ready_o   (pix_ready),
    .frame_clear_i (frame_clear),
    .req_row_i     (req_row),
    .in_row_o      (in_row),
    .row_valid_o   (row_valid),
    .rows_loaded_o (rows_loaded),
    .frame_done_o  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [119:0] frame_row(input int r);
    logic [119:0] w;
    for (int c = 0; c < 15; c++) w[c*8 +: 8] = 8'((16 * r + c) % 256);
    return w;
  endfunction

  function automatic logic [119:0] base_row(input logic [7:0] b);
    logic [119:0] w;
    for (int c = 0; c < 15; c++) w[c*8 +: 8] = b + 8'(c);
    return w;
  endfunction

  // One clock cycle of input, starting and ending on a falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic clr);
    pix_valid   = v;
    pix_data    = d;
    frame_clear = clr;
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_clear = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %b exp 0", pix_ready); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rst_row_valid got %b exp 0", row_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    checks++; if (rows_loaded !== 5'd0) begin errors++; $display("FAIL rst_rows_loaded got %0d exp 0", rows_loaded); end
    checks++; if (in_row !== 120'd0) begin errors++; $display("FAIL rst_in_row got %h exp 0", in_row); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL post_rst_pix_ready got %b exp 1", pix_ready); end
  endtask

  task automatic test_full_load;
    req_row = 64'd2;
    for (int i = 0; i < 225; i++) begin
      cyc(1'b1, 8'((16 * (i / 15) + (i % 15)) % 256), 1'b0);
      if (i + 1 == 44) begin
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL packing_row_valid got %b exp 0", row_valid); end
      end
      if (i + 1 == 45) begin
        checks++; if (rows_loaded !== 5'd3) begin errors++; $display("FAIL rows_after_45 got %0d exp 3", rows_loaded); end
        checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL same_cycle_commit got v=%b %h exp v=0 0", row_valid, in_row); end
      end
      if (i + 1 == 46) begin
        checks++; if (row_valid !== 1'b1 || in_row !== frame_row(2)) begin errors++; $display("FAIL held_req_row2 got v=%b %h exp v=1 %h", row_valid, in_row, frame_row(2)); end
      end
      if (i + 1 == 224) begin
        checks++; if (frame_done !== 1'b0 || pix_ready !== 1'b1) begin errors++; $display("FAIL before_last_beat got done=%b rdy=%b exp 0 1", frame_done, pix_ready); end
      end
    end
    checks++; if (rows_loaded !== 5'd15) begin errors++; $display("FAIL full_rows_loaded got %0d exp 15", rows_loaded); end
    checks++; if (frame_done !== 1'b1 || pix_ready !== 1'b0) begin errors++; $display("FAIL full_flags got done=%b rdy=%b exp 1 0", frame_done, pix_ready); end
    req_row = 64'd3;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (in_row[7:0] !== 8'h30 || in_row[119:112] !== 8'h3E) begin errors++; $display("FAIL row3_ends got %h/%h exp 30/3e", in_row[7:0], in_row[119:112]); end
    checks++; if (row_valid !== 1'b1 || in_row !== frame_row(3)) begin errors++; $display("FAIL row3_word got v=%b %h exp v=1 %h", row_valid, in_row, frame_row(3)); end
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'hFF, 1'b0);
    req_row = 64'd14;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd15) begin errors++; $display("FAIL full_ignores_valid got %0d exp 15", rows_loaded); end
    checks++; if (row_valid !== 1'b1 || in_row !== frame_row(14)) begin errors++; $display("FAIL row14_word got v=%b %h exp v=1 %h", row_valid, in_row, frame_row(14)); end
  endtask

  task automatic test_out_of_range;
    req_row = 64'd20;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL req20 got v=%b %h exp v=0 0", row_valid, in_row); end
    req_row = 64'h0000_0100_0000_0001;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL req_2p40p1 got v=%b %h exp v=0 0", row_valid, in_row); end
    req_row = 64'd15;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL req15 got v=%b %h exp v=0 0", row_valid, in_row); end
  endtask

  task automatic test_clear_coincident;
    req_row = 64'd0;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd0 || frame_done !== 1'b0 || pix_ready !== 1'b1) begin errors++; $display("FAIL clear_state got rl=%0d done=%b rdy=%b exp 0 0 1", rows_loaded, frame_done, pix_ready); end
    checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL clear_read got v=%b %h exp v=0 0", row_valid, in_row); end
    for (int k = 0; k < 20; k++) cyc(1'b1, 8'h40 + 8'(k), 1'b0);
    checks++; if (rows_loaded !== 5'd1) begin errors++; $display("FAIL pre_clear_rows got %0d exp 1", rows_loaded); end
    cyc(1'b1, 8'hAA, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd0 || row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL clear_beat got rl=%0d v=%b %h exp 0 0 0", rows_loaded, row_valid, in_row); end
    for (int k = 0; k < 15; k++) cyc(1'b1, 8'h80 + 8'(k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd1 || row_valid !== 1'b1 || in_row !== base_row(8'h80)) begin errors++; $display("FAIL reload_row0 got rl=%0d v=%b %h exp 1 1 %h", rows_loaded, row_valid, in_row, base_row(8'h80)); end
  endtask

  task automatic test_gap;
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 8'((16 * (i / 15) + (i % 15)) % 256), 1'b0);
      cyc(1'b0, 8'hEE, 1'b0);
    end
    checks++; if (rows_loaded !== 5'd2) begin errors++; $display("FAIL gap_rows got %0d exp 2", rows_loaded); end
    req_row = 64'd0;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (in_row !== frame_row(0)) begin errors++; $display("FAIL gap_row0 got %h exp %h", in_row, frame_row(0)); end
    req_row = 64'd1;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (in_row !== frame_row(1)) begin errors++; $display("FAIL gap_row1 got %h exp %h", in_row, frame_row(1)); end
    for (int c = 0; c < 15; c++) cyc(1'b1, 8'(32 + c), 1'b0);
    req_row = 64'd2;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd3 || in_row !== frame_row(2)) begin errors++; $display("FAIL gap_row2 got rl=%0d %h exp 3 %h", rows_loaded, in_row, frame_row(2)); end
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < 7; c++) cyc(1'b1, 8'(48 + c), 1'b0);
    pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (pix_ready !== 1'b0 || row_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL async_flags got rdy=%b v=%b done=%b exp 0 0 0", pix_ready, row_valid, frame_done); end
    checks++; if (rows_loaded !== 5'd0 || in_row !== 120'd0) begin errors++; $display("FAIL async_data got rl=%0d %h exp 0 0", rows_loaded, in_row); end
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (row_valid !== 1'b0 || in_row !== 120'd0) begin errors++; $display("FAIL post_async_read got v=%b %h exp 0 0", row_valid, in_row); end
    req_row = 64'd0;
    for (int k = 0; k < 15; k++) cyc(1'b1, 8'h10 + 8'(k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (rows_loaded !== 5'd1 || row_valid !== 1'b1 || in_row !== base_row(8'h10)) begin errors++; $display("FAIL post_async_reload got rl=%0d v=%b %h exp 1 1 %h", rows_loaded, row_valid, in_row, base_row(8'h10)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = 8'h00;
    frame_clear = 1'b0;
    req_row     = 64'd0;
    test_reset();
    test_full_load();
    test_out_of_range();
    test_clear_coincident();
    test_gap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
